// File: rtl/data_mem_responder_pkg.sv
// rtl/data_mem_responder_pkg.sv - shared definitions for the data memory responder
// Package dmem_pkg: funct3 size codes, FSM state encoding, access size decode
// and the byte-enable generator used by the store path.
package dmem_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_t;

  // Unlisted funct3 codes behave as word accesses.
  function automatic size_t size_of(input logic [2:0] f3);
    case (f3)
      F3_LB, F3_LBU: size_of = SZ_B;
      F3_LH, F3_LHU: size_of = SZ_H;
      default:       size_of = SZ_W;
    endcase
  endfunction

  // Byte-lane enables for a store; off is expected to be already aligned for H/W.
  function automatic logic [3:0] byte_en(input size_t sz, input logic [1:0] off);
    case (sz)
      SZ_B:    byte_en = 4'b0001 << off;
      SZ_H:    byte_en = off[1] ? 4'b1100 : 4'b0011;
      default: byte_en = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_responder_load_extend.sv
// rtl/data_mem_responder_load_extend.sv - load lane select and sign/zero extension
// Module load_extend (combinational)
//   word   in  32  raw RAM word
//   off    in  2   byte offset within the word (aligned for H/W by the caller)
//   funct3 in  3   access size/sign code
//   rdata  out 32  extended load data
module load_extend
  import dmem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] rdata
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = 8'h00;
    case (off)
      2'd0: b = word[7:0];
      2'd1: b = word[15:8];
      2'd2: b = word[23:16];
      default: b = word[31:24];
    endcase
    h = off[1] ? word[31:16] : word[15:0];

    rdata = word;
    case (funct3)
      F3_LB:   rdata = {{24{b[7]}}, b};
      F3_LBU:  rdata = {24'h0, b};
      F3_LH:   rdata = {{16{h[15]}}, h};
      F3_LHU:  rdata = {16'h0, h};
      default: rdata = word;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - fixed-latency data RAM responder for MemRead/MemWrite
// Services LB/LH/LW/LBU/LHU/SB/SH/SW with WAIT_CYCLES extra busy cycles and
// holds the core via stall until the response cycle.
// Optional feature macro: MISALIGN_TRAP_EN (trap misaligned H/W instead of aligning).
// Ports:
//   clk        in  1   rising-edge clock
//   reset      in  1   synchronous active-high reset
//   mem_read   in  1   load request
//   mem_write  in  1   store request
//   funct3     in  3   access size/sign
//   addr       in  32  byte address
//   wdata      in  32  store data, LSB-aligned
//   rdata      out 32  load data, updated on entry to RESP, held otherwise
//   stall      out 1   core must hold
//   misalign   out 1   one-cycle pulse in RESP for misaligned or read+write requests
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        misalign
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES);

  state_t      state, state_next;
  logic [3:0]  cnt;
  logic [31:0] lat_addr, lat_wdata;
  logic [2:0]  lat_f3;
  logic        lat_wr, lat_ill;

  logic [31:0] ram [DEPTH_WORDS];

  logic        req, in_idle, commit;
  logic [31:0] acc_addr, acc_wdata;
  logic [2:0]  acc_f3;
  logic        acc_wr, acc_ill, acc_mis;
  size_t       acc_sz;
  logic [1:0]  raw_off, off;
  logic [AW-1:0] idx;
  logic [3:0]  be;
  logic [31:0] wword, mem_word, ext_data;
  logic        unused_addr_bits;

  assign req     = mem_read | mem_write;
  assign in_idle = (state == ST_IDLE);

  // With WAIT_CYCLES=0 the commit edge is the accept edge, so the access is
  // taken straight from the ports in IDLE and from the latches afterwards.
  assign acc_addr  = in_idle ? addr      : lat_addr;
  assign acc_wdata = in_idle ? wdata     : lat_wdata;
  assign acc_f3    = in_idle ? funct3    : lat_f3;
  assign acc_wr    = in_idle ? mem_write : lat_wr;
  assign acc_ill   = in_idle ? (mem_read & mem_write) : lat_ill;

  assign acc_sz  = size_of(acc_f3);
  assign raw_off = acc_addr[1:0];

`ifdef MISALIGN_TRAP_EN
  assign acc_mis = ((acc_sz == SZ_H) && raw_off[0]) ||
                   ((acc_sz == SZ_W) && (raw_off != 2'b00));
  assign off     = raw_off;
`else
  assign acc_mis = 1'b0;
  assign off     = (acc_sz == SZ_W) ? 2'b00 :
                   (acc_sz == SZ_H) ? {raw_off[1], 1'b0} : raw_off;
`endif

  // Upper address bits are ignored so the word index wraps modulo DEPTH_WORDS.
  assign idx              = acc_addr[AW+1:2];
  assign unused_addr_bits = ^acc_addr[31:AW+2];
  assign mem_word         = ram[idx];
  assign be               = byte_en(acc_sz, off);

  // Replicate the store data so every enabled lane sees its own bytes.
  always_comb begin
    wword = acc_wdata;
    case (acc_sz)
      SZ_B:    wword = {4{acc_wdata[7:0]}};
      SZ_H:    wword = {2{acc_wdata[15:0]}};
      default: wword = acc_wdata;
    endcase
  end

  load_extend u_load_extend (
    .word   (mem_word),
    .off    (off),
    .funct3 (acc_f3),
    .rdata  (ext_data)
  );

  always_comb begin
    state_next = state;
    stall      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req) begin
          stall      = 1'b1;
          state_next = (WAIT_CYCLES > 0) ? ST_WAIT : ST_RESP;
        end
      end
      ST_WAIT: begin
        stall = 1'b1;
        if (cnt == WAIT_LAST) state_next = ST_RESP;
      end
      ST_RESP: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // A reset on the would-be commit edge drops the pending access.
  assign commit = (state_next == ST_RESP) && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_next;
      if (state_next == ST_WAIT) cnt <= (state == ST_WAIT) ? cnt + 4'd1 : 4'd1;
      else                       cnt <= 4'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lat_addr  <= 32'h0;
      lat_wdata <= 32'h0;
      lat_f3    <= 3'b000;
      lat_wr    <= 1'b0;
      lat_ill   <= 1'b0;
    end else if (in_idle && req) begin
      lat_addr  <= addr;
      lat_wdata <= wdata;
      lat_f3    <= funct3;
      lat_wr    <= mem_write;
      lat_ill   <= mem_read & mem_write;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata    <= 32'h0;
      misalign <= 1'b0;
    end else begin
      misalign <= commit & (acc_mis | acc_ill);
      if (commit && !acc_wr) rdata <= acc_mis ? 32'h0 : ext_data;
    end
  end

  // RAM contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (commit && acc_wr && !acc_mis) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) ram[idx][8*i +: 8] <= wword[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - directed self-checking bench for data_mem_responder
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_rd, a_wr, b_rd, b_wr;
  logic [2:0]  a_f3, b_f3;
  logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
  logic [31:0] a_rdata, b_rdata;
  logic        a_stall, a_mis, b_stall, b_mis;

  int errors = 0;
  int checks = 0;

  logic [31:0] rv;
  logic        mv;
  int          ns;

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(1)) dut (
    .clk(clk), .reset(reset), .mem_read(a_rd), .mem_write(a_wr), .funct3(a_f3),
    .addr(a_addr), .wdata(a_wdata), .rdata(a_rdata), .stall(a_stall), .misalign(a_mis)
  );

  data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .mem_read(b_rd), .mem_write(b_wr), .funct3(b_f3),
    .addr(b_addr), .wdata(b_wdata), .rdata(b_rdata), .stall(b_stall), .misalign(b_mis)
  );

  // Starts just after a rising edge with the DUT in IDLE; returns the RESP-cycle
  // rdata/misalign and the number of stalled cycles before RESP.
  task automatic access(input bit sel, input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rdo, output logic miso, output int nst);
    bit done;
    logic st;
    if (sel) begin b_rd = rd; b_wr = wr; b_f3 = f3; b_addr = a; b_wdata = wd; end
    else     begin a_rd = rd; a_wr = wr; a_f3 = f3; a_addr = a; a_wdata = wd; end
    nst = 0;
    done = 1'b0;
    rdo = 32'h0;
    miso = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      st = sel ? b_stall : a_stall;
      if (st) begin
        nst++;
        @(posedge clk); #1;
      end else begin
        done = 1'b1;
        rdo  = sel ? b_rdata : a_rdata;
        miso = sel ? b_mis : a_mis;
      end
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL access_timeout: stall still %0b after 40 cycles, required 0", st);
    end
    @(posedge clk); #1;
    a_rd = 1'b0; a_wr = 1'b0; b_rd = 1'b0; b_wr = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checks++; if (a_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", a_stall); end
    checks++; if (a_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 00000000", a_rdata); end
    checks++; if (a_mis !== 1'b0) begin errors++; $display("FAIL reset_misalign: got %b expected 0", a_mis); end
    @(posedge clk); #1;
  endtask

  task automatic test_latency;
    access(0, 1, 0, 3'b010, 32'h0000_0040, 32'h0, rv, mv, ns);
    checks++; if (ns != 2) begin errors++; $display("FAIL latency_stall_cycles: got %0d expected 2", ns); end
    checks++; if (mv !== 1'b0) begin errors++; $display("FAIL latency_misalign: got %b expected 0", mv); end
  endtask

  task automatic test_word_and_byte;
    access(0, 0, 1, 3'b010, 32'h10, 32'hDEADBEEF, rv, mv, ns);
    checks++; if (ns != 2 || mv !== 1'b0) begin errors++; $display("FAIL sw_resp: stalls %0d mis %b expected 2 0", ns, mv); end
    access(0, 1, 0, 3'b010, 32'h10, 32'h0, rv, mv, ns);
    checks++; if (rv !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_10: got %h expected deadbeef", rv); end
    access(0, 1, 0, 3'b000, 32'h13, 32'h0, rv, mv, ns);
    checks++; if (rv !== 32'hFFFFFFDE) begin errors++; $display("FAIL lb_13: got %h expected ffffffde", rv); end
    access(0, 1, 0, 3'b100, 32'h13, 32'h0, rv, mv, ns);
    checks++; if (rv !== 32'h000000DE) begin errors++; $display("FAIL lbu_13: got %h expected 000000de", rv); end
    access(0, 1, 0, 3'b001, 32'h10, 32'h0, rv, mv, ns);
    checks++; if (rv !== 32'hFFFFBEEF) begin errors++; $display("FAIL lh_10: got %h expected ffffbeef", rv); end
    access(0, 1, 0, 3'b101, 32'h12, 32'h0, rv, mv, ns);
    checks++; if (rv !== 32'h0000DEAD) begin errors++; $display("FAIL lhu_12: got %h expected 0000dead", rv); end
  endtask

  task automatic test_partial_store;
    access(0, 0, 1, 3'b000, 32'h11, 32'hFFFFFF5A, rv, mv, ns);
    checks++; if (rv !== 32'h0000DEAD) begin errors++; $display("FAIL rdata_hold_on_store: got %h expected 0000dead", rv); end
    access(0, 1, 0, 3'b010, 32'h10, 32'h0, rv, mv, ns);
    checks++; if (rv !== 32'hDEAD5AEF) begin errors++; $display("FAIL sb_then_lw: got %h expected dead5aef", rv); end
    access(0, 0, 1, 3'b001, 32'h12, 32'hABCD1234, rv, mv, ns);
    access(0, 1, 0, 3'b010, 32'h10, 32'h0, rv, mv, ns);
    checks++; if (rv !== 32'h12345AEF) begin errors++; $display("FAIL sh_then_lw: got %h expected 12345aef", rv); end
    access(0, 1, 0, 3'b001, 32'h12, 32'h0, rv, mv, ns);
    checks++; if (rv !== 32'h00001234) begin errors++; $display("FAIL lh_12: got %h expected 00001234", rv); end
    access(0, 1, 0, 3'b000, 32'h11, 32'h0, rv, mv, ns);
    checks++; if (rv !== 32'h0000005A) begin errors++; $display("FAIL lb_11: got %h expected 0000005a", rv); end
  endtask

  task automatic test_reset_mid_wait;
    a_wr = 1'b1; a_f3 = 3'b010; a_addr = 32'h10; a_wdata = 32'h0;
    @(negedge clk);
    checks++; if (a_stall !== 1'b1) begin errors++; $display("FAIL midrst_idle_stall: got %b expected 1", a_stall); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (a_stall !== 1'b1) begin errors++; $display("FAIL midrst_wait_stall: got %b expected 1", a_stall); end
    reset = 1'b1;
    a_wr = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checks++; if (a_stall !== 1'b0 || a_mis !== 1'b0) begin errors++; $display("FAIL midrst_idle: stall %b mis %b expected 0 0", a_stall, a_mis); end
    @(posedge clk); #1;
    access(0, 1, 0, 3'b010, 32'h10, 32'h0, rv, mv, ns);
    checks++; if (rv !== 32'h12345AEF) begin errors++; $display("FAIL midrst_no_commit: got %h expected 12345aef", rv); end
  endtask

  task automatic test_misalign;
`ifdef MISALIGN_TRAP_EN
    access(0, 1, 0, 3'b010, 32'h11, 32'h0, rv, mv, ns);
    checks++; if (rv !== 32'h0 || mv !== 1'b1) begin errors++; $display("FAIL mis_lw_11: rdata %h mis %b expected 00000000 1", rv, mv); end
    @(negedge clk);
    checks++; if (a_mis !== 1'b0) begin errors++; $display("FAIL mis_pulse_width: got %b expected 0", a_mis); end
    @(posedge clk); #1;
    access(0, 0, 1, 3'b010, 32'h12, 32'hFFFFFFFF, rv, mv, ns);
    checks++; if (mv !== 1'b1) begin errors++; $display("FAIL mis_sw_12: mis %b expected 1", mv); end
    access(0, 1, 0, 3'b010, 32'h10, 32'h0, rv, mv, ns);
    checks++; if (rv !== 32'h12345AEF) begin errors++; $display("FAIL mis_no_write: got %h expected 12345aef", rv); end
`else
    access(0, 1, 0, 3'b010, 32'h11, 32'h0, rv, mv, ns);
    checks++; if (rv !== 32'h12345AEF || mv !== 1'b0) begin errors++; $display("FAIL align_lw_11: rdata %h mis %b expected 12345aef 0", rv, mv); end
    access(0, 1, 0, 3'b001, 32'h13, 32'h0, rv, mv, ns);
    checks++; if (rv !== 32'h00001234) begin errors++; $display("FAIL align_lh_13: got %h expected 00001234", rv); end
`endif
  endtask

  task automatic test_illegal;
    access(0, 1, 1, 3'b010, 32'h20, 32'hCAFEF00D, rv, mv, ns);
    checks++; if (mv !== 1'b1) begin errors++; $display("FAIL illegal_misalign: got %b expected 1", mv); end
    access(0, 1, 0, 3'b010, 32'h20, 32'h0, rv, mv, ns);
    checks++; if (rv !== 32'hCAFEF00D || mv !== 1'b0) begin errors++; $display("FAIL illegal_store_commit: rdata %h mis %b expected cafef00d 0", rv, mv); end
    access(0, 1, 0, 3'b010, 32'h420, 32'h0, rv, mv, ns);
    checks++; if (rv !== 32'hCAFEF00D) begin errors++; $display("FAIL addr_wrap: got %h expected cafef00d", rv); end
  endtask

  task automatic test_wait0;
    access(1, 0, 1, 3'b010, 32'h4, 32'h8899AABB, rv, mv, ns);
    checks++; if (ns != 1) begin errors++; $display("FAIL w0_sw_stalls: got %0d expected 1", ns); end
    access(1, 1, 0, 3'b000, 32'h6, 32'h0, rv, mv, ns);
    checks++; if (ns != 1 || rv !== 32'hFFFFFF99) begin errors++; $display("FAIL w0_lb_6: stalls %0d rdata %h expected 1 ffffff99", ns, rv); end
    access(1, 1, 0, 3'b010, 32'h4, 32'h0, rv, mv, ns);
    checks++; if (rv !== 32'h8899AABB) begin errors++; $display("FAIL w0_lw_4: got %h expected 8899aabb", rv); end
  endtask

  initial begin
    reset = 1'b1;
    a_rd = 0; a_wr = 0; a_f3 = 0; a_addr = 0; a_wdata = 0;
    b_rd = 0; b_wr = 0; b_f3 = 0; b_addr = 0; b_wdata = 0;
    test_reset();
    test_latency();
    test_word_and_byte();
    test_partial_store();
    test_reset_mid_wait();
    test_misalign();
    test_illegal();
    test_wait0();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
